// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 4-stage IF/ID/EXE/WB datapath: drives
// register enables, bubbles and EXE_WB->EXE forwarding selects.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  input  logic        id_mc,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_exe_en,
  output logic        id_exe_bubble,
  output logic        exe_wb_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MC_BUSY, DRAIN, HALTED} state_t;

  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

  // Handshake: controls are level signals sampled by the datapath on the
  // rising edge; an instruction moves ID->EXE only when id_exe_en=1 and
  // id_exe_bubble=0 in the same cycle.
  state_t      state;
  logic        live;
  logic [4:0]  exe_rd;
  logic        exe_wen;
  logic [3:0]  mc_cnt;
  logic [1:0]  drain_cnt;
  logic        issue;
  logic        fa_hit;
  logic        fb_hit;

  // exe_wen is never set for rd=0, so register 0 cannot forward.
  assign fa_hit = exe_wen && (id_rs1 == exe_rd);
  assign fb_hit = exe_wen && id_use_rs2 && (id_rs2 == exe_rd);

  // Until the first edge after reset release, controls keep their reset values.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_bubble = 1'b1;
    exe_wb_bubble = 1'b1;
    issue         = 1'b0;
    if (live) begin
      case (state)
        RUN: begin
          if (halt_req) begin
            exe_wb_bubble = 1'b0;
          end else begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_exe_bubble = !id_valid;
            exe_wb_bubble = 1'b0;
            issue         = id_valid;
          end
        end
        MC_BUSY: begin
          id_exe_en     = 1'b0;
          id_exe_bubble = 1'b0;
        end
        DRAIN, HALTED: begin
          exe_wb_bubble = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      live      <= 1'b0;
      exe_rd    <= 5'd0;
      exe_wen   <= 1'b0;
      mc_cnt    <= 4'd0;
      drain_cnt <= 2'd0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      halted    <= 1'b0;
      stall_cnt <= 16'd0;
    end else if (!live) begin
      live <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
            exe_wen   <= 1'b0;
            fwd_a     <= 2'b00;
            fwd_b     <= 2'b00;
          end else if (issue) begin
            exe_rd  <= id_rd;
            exe_wen <= id_wen && (id_rd != 5'd0);
            fwd_a   <= {1'b0, fa_hit};
            fwd_b   <= {1'b0, fb_hit};
            if (id_mc) begin
              state  <= MC_BUSY;
              mc_cnt <= MC_INIT;
            end
          end else begin
            exe_wen <= 1'b0;
            fwd_a   <= 2'b00;
            fwd_b   <= 2'b00;
          end
        end
        MC_BUSY: begin
          mc_cnt <= mc_cnt - 4'd1;
          if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          if (mc_cnt == 4'd1) state <= RUN;
        end
        DRAIN: begin
          exe_wen <= 1'b0;
          fwd_a   <= 2'b00;
          fwd_b   <= 2'b00;
          if (drain_cnt == 2'd1) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MC_LAT = 4;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        id_mc;
  logic        halt_req;
  logic        pc_en;
  logic        if_id_en;
  logic        id_exe_en;
  logic        id_exe_bubble;
  logic        exe_wb_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        halted;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen), .id_mc(id_mc),
    .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .id_exe_bubble(id_exe_bubble), .exe_wb_bubble(exe_wb_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: [25]pc [24]if_id [23]id_exe_en [22]bubble [21]exe_wb_bubble
  // [20:19]fwd_a [18:17]fwd_b [16]halted [15:0]stall_cnt
  logic [25:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;

  // behavioural model: pipeline described by remaining-cycle counters
  int m_live, m_stall_left, m_drain_left, m_halted, m_dest, m_fa, m_fb, m_sc;

  task automatic m_reset();
    m_live = 0; m_stall_left = 0; m_drain_left = 0; m_halted = 0;
    m_dest = -1; m_fa = 0; m_fb = 0; m_sc = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // driver: applies one cycle of inputs, queues the expected response, then
  // advances the model across the rising edge
  task automatic cyc(input bit r, input bit v, input int rs1, input int rs2,
                     input bit u2, input int rd, input bit w, input bit mc, input bit h);
    bit pc, ifid, en, bub, ewb;
    rst = r; id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs2 = u2;
    id_rd = 5'(rd); id_wen = w; id_mc = mc; halt_req = h;
    if (r) m_reset();
    pc = 0; ifid = 0; en = 1; bub = 1; ewb = 1;
    if (r || m_live == 0) begin
    end else if (m_halted != 0 || m_drain_left > 0) begin
      ewb = 0;
    end else if (m_stall_left > 0) begin
      en = 0; bub = 0; ewb = 1;
    end else if (h) begin
      ewb = 0;
    end else begin
      pc = 1; ifid = 1; en = 1; bub = !v; ewb = 0;
    end
    exp_q.push_back({pc, ifid, en, bub, ewb, 2'(m_fa), 2'(m_fb), m_halted[0], 16'(m_sc)});
    @(posedge clk);
    cyc_no++;
    if (r) begin
      m_reset();
    end else if (m_live == 0) begin
      m_live = 1;
    end else if (m_halted != 0) begin
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
      if (m_sc < 65535) m_sc++;
    end else if (h) begin
      m_drain_left = 2; m_fa = 0; m_fb = 0; m_dest = -1;
    end else if (v) begin
      m_fa = (m_dest >= 0 && rs1 == m_dest) ? 1 : 0;
      m_fb = (m_dest >= 0 && u2 && rs2 == m_dest) ? 1 : 0;
      m_dest = (w && rd != 0) ? rd : -1;
      if (mc) m_stall_left = MC_LAT - 1;
    end else begin
      m_fa = 0; m_fb = 0; m_dest = -1;
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [25:0] e, a, mask;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_en, if_id_en, id_exe_en, id_exe_bubble, exe_wb_bubble, fwd_a, fwd_b, halted, stall_cnt};
      mask = '1;
      if (!e[23]) mask[22] = 1'b0;
      n_vec++;
      if (((a ^ e) & mask) != '0) begin
        n_err++;
        $display("FAIL ctrl_vector cycle %0d: got %h expected %h", cyc_no, a, e);
      end
    end
  end

  initial begin
    m_reset();
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    id_rd = 0; id_wen = 0; id_mc = 0; halt_req = 0;
    @(posedge clk); #1;

    // reset with random inputs
    repeat (2) cyc(1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom),
                   $urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_pc_en", pc_en, 0);
    idle();

    // back-to-back dependency
    cyc(0, 1, 1, 2, 1, 3, 1, 0, 0);
    cyc(0, 1, 3, 3, 1, 4, 1, 0, 0);
    chk("dep_fwd_a", fwd_a, 1);
    chk("dep_fwd_b", fwd_b, 1);
    cyc(0, 1, 1, 2, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 4, 1, 0, 0);
    chk("r0_fwd_a", fwd_a, 0);
    chk("r0_fwd_b", fwd_b, 0);

    // immediate operand must not forward on rs2
    cyc(0, 1, 1, 2, 1, 6, 1, 0, 0);
    cyc(0, 1, 1, 6, 0, 7, 1, 0, 0);
    chk("imm_fwd_b", fwd_b, 0);

    // multi-cycle producer, consumer held in ID
    cyc(0, 1, 1, 2, 1, 5, 1, 1, 0);
    repeat (MC_LAT) cyc(0, 1, 5, 0, 1, 8, 1, 0, 0);
    chk("mc_fwd_a", fwd_a, 1);
    chk("mc_stall_cnt", stall_cnt, MC_LAT - 1);

    // halt beats a multi-cycle op in ID
    cyc(0, 1, 1, 2, 1, 9, 1, 1, 1);
    cyc(0, 1, 1, 2, 1, 9, 1, 1, 1);
    chk("halt_2_edges", halted, 0);
    cyc(0, 1, 1, 2, 1, 9, 1, 1, 1);
    chk("halt_3_edges", halted, 1);
    chk("halt_pc_en", pc_en, 0);
    repeat (3) idle();

    // reset during the second MC_BUSY cycle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 1, 1, 2, 1, 7, 1, 1, 0);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_rst_stall_cnt", stall_cnt, 0);
    idle();
    cyc(0, 1, 7, 7, 1, 8, 1, 0, 0);
    chk("post_rst_fwd_a", fwd_a, 0);
    chk("post_rst_pc_en", pc_en, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0) || (m_halted != 0 && $urandom_range(0, 3) == 0);
      cyc(r, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 39) == 0));
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 4-stage IF/ID/EXE/WB regfile datapath. It decides each cycle whether PC, IF_ID and ID_EXE advance, when bubbles are inserted, and when operands are forwarded from EXE_WB into EXE. It holds EXE for multi-cycle ALU operations and drains the pipe to a sticky halt. It sits beside the datapath and drives its register enables and forwarding muxes.

## Interface
- MC_LAT, 4: total EXE occupancy in cycles of a multi-cycle op; legal 2..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_use_rs2  in  1  rs2 is read (0 when the immediate is selected, alusrc=1).
- id_rd  in  5  ID destination register.
- id_wen  in  1  ID instruction writes rd.
- id_mc  in  1  ID instruction is a multi-cycle op.
- halt_req  in  1  level request to drain and stop; sampled only in RUN.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF_ID capture enable.
- id_exe_en  out  1  ID_EXE capture enable (0 = hold).
- id_exe_bubble  out  1  ID_EXE loads a NOP (waddr 0, no write); valid only when id_exe_en=1.
- exe_wb_bubble  out  1  EXE_WB loads a NOP instead of aluout.
- fwd_a  out  2  EXE operand A select: 00 = rdata1_ID_EXE, 01 = aluout_EXE_WB.
- fwd_b  out  2  same for operand B; forced 00 when id_use_rs2=0 at issue.
- halted  out  1  pipe drained and stopped.
- stall_cnt  out  16  saturating count of MC_BUSY cycles.

## Operation
- States: RUN, MC_BUSY, DRAIN, HALTED. Internal: exe_rd[4:0], exe_wen (instruction currently in ID_EXE), mc_cnt[3:0], drain_cnt[1:0].
- RUN, halt_req=1: go DRAIN. ID instruction is not issued (bubble), even if id_mc=1. Halt has priority.
- RUN, halt_req=0: pc_en=if_id_en=id_exe_en=1, exe_wb_bubble=0. Issue = id_valid; id_exe_bubble = !id_valid.
- On issue: exe_rd<=id_rd; exe_wen<=id_wen & (id_rd!=0). On bubble: exe_wen<=0.
- Forwarding is computed at issue against the current exe_rd/exe_wen and registered with the instruction. fwd_a=01 iff exe_wen & id_rs1==exe_rd; fwd_b=01 iff exe_wen & id_use_rs2 & id_rs2==exe_rd; else 00. Register 0 never forwards. The regfile is write-through, so WB-to-ID distance needs no forwarding.
- Issue with id_mc=1: go MC_BUSY, mc_cnt<=MC_LAT-1.
- MC_BUSY: pc_en=if_id_en=id_exe_en=0, exe_wb_bubble=1. fwd_a/fwd_b and exe_rd are held. mc_cnt decrements. At mc_cnt==1 the next state is RUN. The op's final EXE cycle is the RUN cycle, where EXE_WB captures its result. halt_req is ignored in this state.
- DRAIN: pc_en=if_id_en=0, id_exe_en=1, id_exe_bubble=1, exe_wb_bubble=0. Lasts 2 cycles (EXE then WB empty), then HALTED.
- HALTED: same controls as DRAIN, halted=1. Exits only via rst.
- stall_cnt increments each MC_BUSY cycle and saturates at 0xFFFF.

## Timing
- While rst=1 and after release, until first edge: state RUN, pc_en=0, if_id_en=0, id_exe_en=1, id_exe_bubble=1, exe_wb_bubble=1, fwd_a=fwd_b=00, halted=0, stall_cnt=0, exe_wen=0, mc_cnt=0.
- After rst deasserts: controls follow RUN rules combinationally. fwd_a, fwd_b, halted, stall_cnt are registered.
- Multi-cycle op: MC_LAT-1 stall cycles plus 1 RUN cycle in EXE. The dependent next instruction issues in that RUN cycle with fwd=01.
- Single-cycle back-to-back dependency: zero stall cycles, fwd=01.
- rst mid-MC_BUSY or mid-DRAIN: immediate return to reset values; the in-flight op is abandoned.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> pc_en=0, id_exe_bubble=1, exe_wb_bubble=1, fwd 00, halted=0, stall_cnt=0.
- ADD r3 then SUB r4=r3-r3 back to back -> SUB in EXE with fwd_a=01, fwd_b=01, no stall. Same sequence with rd=r0 -> fwd 00.
- MC op to r5 (MC_LAT=4), then use of r5 -> exactly 3 cycles with pc_en=0 and exe_wb_bubble=1. Consumer issues on the 4th cycle with fwd_a=01. stall_cnt=3.
- id_use_rs2=0 with id_rs2==exe_rd -> fwd_b=00.
- halt_req=1 with id_mc=1 in ID in RUN -> no MC_BUSY, bubble issued, halted=1 exactly 3 edges later, pc_en stays 0.
- rst pulsed on the 2nd MC_BUSY cycle -> RUN on release, stall_cnt=0, next instruction issues normally.
